// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared funct3 codes, FSM encoding and byte-enable helper for the data-memory controller
package cpu_mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  function automatic logic [3:0] be_for(input logic [2:0] funct3, input logic [1:0] addr_lo);
    be_for = (funct3 == F3_B || funct3 == F3_BU) ? 4'b0001 << addr_lo :
             (funct3 == F3_H || funct3 == F3_HU) ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
             funct3 == F3_W ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/cpu_dmem_lane_extract.sv
// cpu_dmem_lane_extract: aligns the addressed lane of a read word and sign/zero-extends it
module cpu_dmem_lane_extract
  import cpu_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [31:0] sh;
  assign sh = word >> {addr_lo, 3'b000};
  assign data = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                funct3 == F3_BU ? {24'b0, sh[7:0]} :
                funct3 == F3_HU ? {16'b0, sh[15:0]} :
                funct3 == F3_W  ? sh : '0;
endmodule

// File: rtl/cpu_dmem_access_ctrl.sv
// cpu_dmem_access_ctrl: single-outstanding load/store controller for a byte-strobed req/ack data bus
module cpu_dmem_access_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [1:0]    state;
  logic [31:0]   addr_q, wdata_q, word_q, ext;
  logic [2:0]    f3_q;
  logic          we_q, err_q;
  logic [CW-1:0] cnt;
  logic          f3_ok, align_ok, legal, accept, bus, resp, timeout;
  assign f3_ok = req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W ||
                 (req_load && (req_funct3 == F3_BU || req_funct3 == F3_HU));
  assign align_ok = (req_funct3 == F3_H || req_funct3 == F3_HU) ? !req_addr[0] :
                    req_funct3 == F3_W ? req_addr[1:0] == 2'b00 : 1'b1;
  assign legal   = (req_load ^ req_store) && f3_ok && align_ok;
  assign accept  = state == S_IDLE && req_valid && (req_load || req_store);
  assign bus     = state == S_BUS;
  assign resp    = state == S_RESP;
  assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      f3_q    <= req_funct3;
      we_q    <= req_store;
      err_q   <= !legal;
      cnt     <= '0;
      state   <= legal ? S_BUS : S_RESP;
    end else if (bus) begin
      // ack is checked first so a same-cycle ack beats the timeout
      if (mem_ack) begin
        word_q <= mem_rdata;
        state  <= S_RESP;
      end else if (timeout) begin
        err_q <= 1'b1;
        state <= S_RESP;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (resp) begin
      state <= S_IDLE;
    end
  end
  cpu_dmem_lane_extract u_extract (
    .word    (word_q),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .data    (ext)
  );
  assign req_ready  = state == S_IDLE;
  assign busy       = bus || resp;
  assign resp_valid = resp;
  assign resp_err   = resp && err_q;
  assign resp_rdata = (resp && !err_q && !we_q) ? ext : '0;
  assign mem_req    = bus;
  assign mem_we     = bus && we_q;
  assign mem_addr   = bus ? {addr_q[31:2], 2'b00} : '0;
  assign mem_be     = bus ? be_for(f3_q, addr_q[1:0]) : '0;
  assign mem_wdata  = !(bus && we_q) ? '0 :
                      f3_q == F3_B ? {4{wdata_q[7:0]}} :
                      f3_q == F3_H ? {2{wdata_q[15:0]}} : wdata_q;
endmodule

// File: tb/tb_cpu_dmem_access_ctrl.sv
// tb_cpu_dmem_access_ctrl: directed self-checking bench for the data-memory access controller
module tb_cpu_dmem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_load, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  int checks = 0;
  int failures = 0;
  int n;
  always #5 clk = ~clk;
  cpu_dmem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_load(req_load), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_load = ld; req_store = st;
    req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
  endtask
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rd, input logic [3:0] be, input logic [31:0] exp);
    issue(1'b1, 1'b0, f3, addr, 32'hDEAD_BEEF);
    chk({tag, "_req"}, {31'b0, mem_req}, 32'd1);
    chk({tag, "_be"}, {28'b0, mem_be}, {28'b0, be});
    chk({tag, "_we_wdata"}, mem_wdata | {31'b0, mem_we}, 32'd0);
    mem_ack = 1'b1; mem_rdata = rd;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    chk({tag, "_resp"}, {30'b0, resp_valid, resp_err}, 32'b10);
    chk({tag, "_rdata"}, resp_rdata, exp);
    @(negedge clk);
    chk({tag, "_idle"}, {30'b0, resp_valid, req_ready}, 32'b01);
  endtask
  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    req_funct3 = '0; req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_ctl", {26'b0, resp_valid, resp_err, busy, mem_req, mem_we, 1'b0}, 32'd0);
    chk("rst_buses", mem_addr | mem_wdata | resp_rdata | {28'b0, mem_be}, 32'd0);
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    // SB to lane 3, ack on the second bus cycle
    issue(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5);
    chk("sb_be", {28'b0, mem_be}, 32'h8);
    chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("sb_addr", mem_addr, 32'h0000_1000);
    chk("sb_ctl", {28'b0, mem_req, mem_we, busy, req_ready}, 32'b1110);
    @(negedge clk);
    chk("sb_hold", {31'b0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("sb_resp", {29'b0, resp_valid, resp_err, mem_req}, 32'b100);
    chk("sb_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    chk("sb_idle", {30'b0, resp_valid, req_ready}, 32'b01);
    do_load("lh",  3'b001, 32'h0000_2002, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h0000_2002, 32'h8001_1234, 4'b1100, 32'h0000_8001);
    do_load("lb",  3'b000, 32'h0000_3001, 32'h0000_7F00, 4'b0010, 32'h0000_007F);
    do_load("lbu", 3'b100, 32'h0000_3003, 32'hF000_0000, 4'b1000, 32'h0000_00F0);
    // illegal requests answer next cycle with no bus activity
    issue(1'b1, 1'b0, 3'b010, 32'h0000_4002, 32'h0);
    chk("mis_resp", {29'b0, resp_valid, resp_err, mem_req}, 32'b110);
    chk("mis_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    chk("mis_idle", {30'b0, mem_req, req_ready}, 32'b01);
    issue(1'b0, 1'b1, 3'b100, 32'h0000_4000, 32'h0);
    chk("sbu_resp", {29'b0, resp_valid, resp_err, mem_req}, 32'b110);
    @(negedge clk);
    issue(1'b0, 1'b0, 3'b010, 32'h0000_4000, 32'h0);
    chk("none_ignored", {29'b0, req_ready, busy, resp_valid}, 32'b100);
    // no ack: mem_req stays up for exactly TIMEOUT_CYCLES
    issue(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0);
    n = 0;
    while (mem_req && n < 20) begin n++; @(negedge clk); end
    chk("to_cycles", n, 32'd4);
    chk("to_resp", {30'b0, resp_valid, resp_err}, 32'b11);
    @(negedge clk);
    chk("to_ready", {31'b0, req_ready}, 32'd1);
    // ack on the final allowed cycle wins over timeout
    issue(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("ackwin_resp", {30'b0, resp_valid, resp_err}, 32'b10);
    chk("ackwin_rdata", resp_rdata, 32'hCAFE_F00D);
    @(negedge clk);
    // async reset in the middle of a bus cycle
    issue(1'b0, 1'b1, 3'b010, 32'h0000_7000, 32'h1111_2222);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctl", {28'b0, mem_req, busy, resp_valid, req_ready}, 32'b0001);
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); n += int'(resp_valid); end
    chk("arst_noresp", n, 32'd0);
    do_load("post_lw", 3'b010, 32'h0000_5000, 32'h1234_5678, 4'b1111, 32'h1234_5678);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
